// File: rtl/qsys_mlcd_bus_ctrl_pkg.sv
// Shared types and constants for the Avalon-MM to 8080-style LCD bus controller.
package qsys_mlcd_pkg;

  // Bus-cycle phases; DONE is the single cycle that releases the Avalon master.
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } state_t;

  // Avalon register map (word addresses).
  localparam logic [1:0] ADDR_CMD    = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_TIMING = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  // TIMING register layout: S at [3:0], W at [11:8], R at [19:16], H at [27:24].
  localparam int unsigned   TIM_S_LSB  = 0;
  localparam int unsigned   TIM_W_LSB  = 8;
  localparam int unsigned   TIM_R_LSB  = 16;
  localparam int unsigned   TIM_H_LSB  = 24;
  localparam logic [31:0]   TIMING_RST  = 32'h0108_0201;
  localparam logic [31:0]   TIMING_MASK = 32'h0F0F_0F0F;

  // CTRL/STATUS bit positions.
  localparam int unsigned   STAT_BUSY_BIT = 0;
  localparam int unsigned   CTRL_RST_BIT  = 1;

endpackage

// File: rtl/qsys_mlcd_bus_ctrl_if.sv
// Avalon-MM slave port plus LCD pin bundle for the LCD bus controller.
interface qsys_mlcd_bus_ctrl_if #(
  parameter int DW = 16
);
  logic [1:0]    avs_address;
  logic          avs_read;
  logic          avs_write;
  logic [31:0]   avs_writedata;
  logic [31:0]   avs_readdata;
  logic          avs_waitrequest;
  logic          lcd_cs_n;
  logic          lcd_rs;
  logic          lcd_wr_n;
  logic          lcd_rd_n;
  logic          lcd_rst_n;
  logic [DW-1:0] lcd_data_out;
  logic          lcd_data_oe;
  logic [DW-1:0] lcd_data_in;

  // Controller side.
  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, lcd_data_in,
    output avs_readdata, avs_waitrequest,
    output lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_rst_n, lcd_data_out, lcd_data_oe
  );

  // CPU / board side.
  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, lcd_data_in,
    input  avs_readdata, avs_waitrequest,
    input  lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_rst_n, lcd_data_out, lcd_data_oe
  );
endinterface

// File: rtl/qsys_mlcd_bus_ctrl.sv
// Runs one complete 8080-style LCD bus cycle per Avalon access to CMD/DATA,
// stalling the CPU with waitrequest until the cycle finishes.
module qsys_mlcd_bus_ctrl
  import qsys_mlcd_pkg::*;
#(
  parameter int TW = 4,
  parameter int DW = 16
) (
  input logic                 clk,
  input logic                 reset,
  qsys_mlcd_bus_ctrl_if.slave bus
);

  state_t          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [31:0]     timing_q;
  logic            rst_n_q;
  logic            is_wr_q;
  logic            rs_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   latch_q;
  logic            cs_n_q, wr_n_q, rd_n_q, oe_q;
  logic            cs_n_d, wr_n_d, rd_n_d, oe_d;

  logic            any_req, lcd_acc, reg_acc, accept, dir_d, active_d, sample_rd;
  logic [TW-1:0]   tim_s, tim_w, tim_r, tim_h, strobe_len;
  logic [31:0]     status;

  // A zero field behaves as one cycle; the counter holds (length - 1).
  function automatic logic [TW-1:0] phase_load(input logic [TW-1:0] f);
    return (f == '0) ? '0 : f - 1'b1;
  endfunction

  assign any_req    = bus.avs_read | bus.avs_write;
  assign lcd_acc    = any_req & ~bus.avs_address[1];
  assign reg_acc    = any_req &  bus.avs_address[1];
  assign accept     = (state_q == IDLE) & lcd_acc;
  assign sample_rd  = (state_q == STROBE) & (cnt_q == '0) & ~is_wr_q;

  assign tim_s      = timing_q[TIM_S_LSB +: TW];
  assign tim_w      = timing_q[TIM_W_LSB +: TW];
  assign tim_r      = timing_q[TIM_R_LSB +: TW];
  assign tim_h      = timing_q[TIM_H_LSB +: TW];
  assign strobe_len = is_wr_q ? tim_w : tim_r;

  // Phase sequencing: state and phase down-counter.
  always_comb begin
    // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = SETUP;
        cnt_d   = phase_load(tim_s);
      end
      SETUP: if (cnt_q == '0) begin
        state_d = STROBE;
        cnt_d   = phase_load(strobe_len);
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      STROBE: if (cnt_q == '0) begin
        state_d = HOLD;
        cnt_d   = phase_load(tim_h);
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      HOLD: if (cnt_q == '0) begin
        state_d = DONE;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin values for the next cycle, decoded from the next state so the pins come straight from flops.
  always_comb begin
    dir_d    = accept ? bus.avs_write : is_wr_q;
    active_d = (state_d == SETUP) | (state_d == STROBE) | (state_d == HOLD);
    cs_n_d   = ~active_d;
    oe_d     = active_d & dir_d;
    wr_n_d   = ~((state_d == STROBE) & dir_d);
    rd_n_d   = ~((state_d == STROBE) & ~dir_d);
  end

  // State, counter and glitch-free pin registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cs_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_n_q  <= cs_n_d;
      wr_n_q  <= wr_n_d;
      rd_n_q  <= rd_n_d;
      oe_q    <= oe_d;
    end
  end

  // Capture the access on accept and latch panel data at the end of the read strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_wr_q <= 1'b0;
      rs_q    <= 1'b0;
      wdata_q <= '0;
      latch_q <= '0;
    end else begin
      if (accept) begin
        is_wr_q <= bus.avs_write;
        rs_q    <= bus.avs_address[0];
        wdata_q <= bus.avs_writedata[DW-1:0];
      end
      if (sample_rd) latch_q <= bus.lcd_data_in;
    end
  end

  // TIMING and CTRL writes take effect only in IDLE; elsewhere the master is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timing_q <= TIMING_RST;
      rst_n_q  <= 1'b0;
    end else if (state_q == IDLE && bus.avs_write) begin
      if (bus.avs_address == ADDR_TIMING) timing_q <= bus.avs_writedata & TIMING_MASK;
      if (bus.avs_address == ADDR_CTRL)   rst_n_q  <= bus.avs_writedata[CTRL_RST_BIT];
    end
  end

  // Stall LCD accesses until DONE, register accesses until IDLE; drive the read mux only during reads.
  always_comb begin
    status                = '0;
    status[STAT_BUSY_BIT] = (state_q != IDLE);
    status[CTRL_RST_BIT]  = rst_n_q;

    bus.avs_waitrequest = (lcd_acc & (state_q != DONE)) | (reg_acc & (state_q != IDLE));

    bus.avs_readdata = '0;
    if (bus.avs_read) begin
      unique case (bus.avs_address)
        ADDR_CMD, ADDR_DATA: bus.avs_readdata = {{(32-DW){1'b0}}, latch_q};
        ADDR_TIMING:         bus.avs_readdata = timing_q;
        default:             bus.avs_readdata = status;
      endcase
    end
  end

  assign bus.lcd_cs_n     = cs_n_q;
  assign bus.lcd_wr_n     = wr_n_q;
  assign bus.lcd_rd_n     = rd_n_q;
  assign bus.lcd_data_oe  = oe_q;
  assign bus.lcd_rs       = rs_q;
  assign bus.lcd_data_out = wdata_q;
  assign bus.lcd_rst_n    = rst_n_q;

endmodule

// File: tb/tb_qsys_mlcd_bus_ctrl.sv
// Self-checking bench for qsys_mlcd_bus_ctrl: directed scenarios plus randomized
// accesses compared against a cycle-count model derived from the TIMING fields.
module tb_qsys_mlcd_bus_ctrl;
  import qsys_mlcd_pkg::*;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  qsys_mlcd_bus_ctrl_if #(.DW(DW)) bus ();
  qsys_mlcd_bus_ctrl #(.TW(4), .DW(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Panel model: presents panel_val only while RD is low, its complement otherwise.
  logic [15:0] panel_val;
  assign bus.lcd_data_in = bus.lcd_rd_n ? ~panel_val : panel_val;

  int checks   = 0;
  int failures = 0;

  // Reference state: TIMING contents and LCD reset pin.
  logic [31:0] tim_m;
  logic        rst_m;

  // Results of the most recent access.
  logic [31:0] r_rdata;
  int r_cycles, r_cs_low, r_wr_low, r_rd_low, r_bad_rs, r_bad_oe, r_bad_data, r_stray;
  logic r_timeout, r_first_cs_n;

  function automatic int flen(input logic [3:0] f);
    return (f == 4'd0) ? 1 : int'(f);
  endfunction

  function automatic int exp_len(input logic [31:0] t, input logic wr);
    return flen(t[3:0]) + (wr ? flen(t[11:8]) : flen(t[19:16])) + flen(t[27:24]) + 2;
  endfunction

  // Performs one Avalon access starting at a falling edge; returns at the next falling edge after completion.
  task automatic access(input logic [1:0] addr, input logic wr, input logic [31:0] wdata);
    logic done;
    done = 1'b0;
    r_cycles = 0; r_cs_low = 0; r_wr_low = 0; r_rd_low = 0;
    r_bad_rs = 0; r_bad_oe = 0; r_bad_data = 0; r_stray = 0;
    r_timeout = 1'b0; r_rdata = '0; r_first_cs_n = 1'b0;
    bus.avs_address   = addr;
    bus.avs_write     = wr;
    bus.avs_read      = ~wr;
    bus.avs_writedata = wdata;
    for (int i = 0; i < 200; i++) begin
      #1;
      r_cycles++;
      if (i == 0) r_first_cs_n = bus.lcd_cs_n;
      if (!bus.lcd_cs_n) begin
        r_cs_low++;
        if (bus.lcd_rs !== addr[0]) r_bad_rs++;
        if (bus.lcd_data_oe !== wr) r_bad_oe++;
        if (wr && bus.lcd_data_out !== wdata[15:0]) r_bad_data++;
      end else if (!bus.lcd_wr_n || !bus.lcd_rd_n || bus.lcd_data_oe) begin
        r_stray++;
      end
      if (!bus.lcd_wr_n) r_wr_low++;
      if (!bus.lcd_rd_n) r_rd_low++;
      if (!bus.avs_waitrequest) begin
        r_rdata = bus.avs_readdata;
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) r_timeout = 1'b1;
    @(negedge clk);
    bus.avs_read  = 1'b0;
    bus.avs_write = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus.lcd_cs_n, bus.lcd_wr_n, bus.lcd_rd_n, bus.lcd_rst_n, bus.lcd_data_oe, bus.lcd_rs} !== 6'b111000) begin
      failures++;
      $display("FAIL reset_pins: got cs/wr/rd/rst/oe/rs=%b required 111000",
               {bus.lcd_cs_n, bus.lcd_wr_n, bus.lcd_rd_n, bus.lcd_rst_n, bus.lcd_data_oe, bus.lcd_rs});
    end
    checks++;
    if (bus.lcd_data_out !== 16'h0 || bus.avs_readdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: got data_out=%h readdata=%h required 0", bus.lcd_data_out, bus.avs_readdata);
    end
    @(negedge clk);
    reset = 1'b0;
    tim_m = 32'h0108_0201;
    rst_m = 1'b0;
    access(ADDR_TIMING, 1'b0, 32'h0);
    checks++;
    if (r_rdata !== 32'h0108_0201 || r_cycles != 1) begin
      failures++;
      $display("FAIL reset_timing: got %h in %0d cycles required 01080201 in 1", r_rdata, r_cycles);
    end
    access(ADDR_CTRL, 1'b0, 32'h0);
    checks++;
    if (r_rdata !== 32'h0 || r_cycles != 1) begin
      failures++;
      $display("FAIL reset_status: got %h in %0d cycles required 0 in 1", r_rdata, r_cycles);
    end
  endtask

  task automatic test_ctrl;
    access(ADDR_CTRL, 1'b1, 32'h0000_0002);
    rst_m = 1'b1;
    checks++;
    if (r_cycles != 1 || bus.lcd_rst_n !== 1'b1) begin
      failures++;
      $display("FAIL ctrl_write: got %0d cycles rst_n=%b required 1 cycle rst_n=1", r_cycles, bus.lcd_rst_n);
    end
    access(ADDR_CTRL, 1'b0, 32'h0);
    checks++;
    if (r_rdata !== 32'h2) begin
      failures++;
      $display("FAIL ctrl_status: got %h required 00000002", r_rdata);
    end
  endtask

  task automatic test_cmd_write;
    access(ADDR_CMD, 1'b1, 32'h0000_002C);
    checks++;
    if (r_timeout || r_cycles != 6) begin
      failures++;
      $display("FAIL cmd_len: got %0d cycles (timeout=%b) required 6", r_cycles, r_timeout);
    end
    checks++;
    if (r_wr_low != 2 || r_rd_low != 0 || r_cs_low != 4) begin
      failures++;
      $display("FAIL cmd_strobe: got wr_low=%0d rd_low=%0d cs_low=%0d required 2 0 4", r_wr_low, r_rd_low, r_cs_low);
    end
    checks++;
    if (r_bad_rs != 0 || r_bad_data != 0 || r_bad_oe != 0 || r_stray != 0) begin
      failures++;
      $display("FAIL cmd_pins: got bad rs=%0d data=%0d oe=%0d stray=%0d required all 0",
               r_bad_rs, r_bad_data, r_bad_oe, r_stray);
    end
  endtask

  task automatic test_timing_read;
    access(ADDR_TIMING, 1'b1, 32'h0203_0402);
    tim_m = 32'h0203_0402;
    access(ADDR_TIMING, 1'b0, 32'h0);
    checks++;
    if (r_rdata !== 32'h0203_0402) begin
      failures++;
      $display("FAIL timing_readback: got %h required 02030402", r_rdata);
    end
    panel_val = 16'hA55A;
    access(ADDR_DATA, 1'b0, 32'h0);
    checks++;
    if (r_timeout || r_cycles != 9 || r_rd_low != 3 || r_wr_low != 0) begin
      failures++;
      $display("FAIL data_read_timing: got len=%0d rd_low=%0d wr_low=%0d required 9 3 0", r_cycles, r_rd_low, r_wr_low);
    end
    checks++;
    if (r_rdata !== 32'h0000_A55A || r_bad_rs != 0 || r_bad_oe != 0) begin
      failures++;
      $display("FAIL data_read_value: got %h bad_rs=%0d bad_oe=%0d required 0000a55a 0 0", r_rdata, r_bad_rs, r_bad_oe);
    end
  endtask

  task automatic test_zero_timing;
    access(ADDR_TIMING, 1'b1, 32'h0);
    tim_m = 32'h0;
    access(ADDR_DATA, 1'b1, 32'h0000_1234);
    checks++;
    if (r_cycles != 5 || r_wr_low != 1 || r_cs_low != 3) begin
      failures++;
      $display("FAIL zero_write: got len=%0d wr_low=%0d cs_low=%0d required 5 1 3", r_cycles, r_wr_low, r_cs_low);
    end
    panel_val = 16'h3C96;
    access(ADDR_CMD, 1'b0, 32'h0);
    checks++;
    if (r_cycles != 5 || r_rd_low != 1 || r_rdata !== 32'h0000_3C96) begin
      failures++;
      $display("FAIL zero_read: got len=%0d rd_low=%0d data=%h required 5 1 00003c96", r_cycles, r_rd_low, r_rdata);
    end
  endtask

  task automatic test_back_to_back;
    access(ADDR_TIMING, 1'b1, 32'h0108_0201);
    tim_m = 32'h0108_0201;
    access(ADDR_DATA, 1'b1, 32'h0000_BEEF);
    access(ADDR_DATA, 1'b1, 32'h0000_CAFE);
    checks++;
    if (r_cycles != 6 || r_first_cs_n !== 1'b1 || r_bad_data != 0 || r_wr_low != 2) begin
      failures++;
      $display("FAIL b2b_second: got len=%0d first_cs_n=%b bad_data=%0d wr_low=%0d required 6 1 0 2",
               r_cycles, r_first_cs_n, r_bad_data, r_wr_low);
    end
  endtask

  task automatic test_random;
    int kind, exp_cyc;
    logic [31:0] wd;
    logic [1:0] a;
    logic wr;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      wd   = $urandom;
      if (kind == 0) begin
        access(ADDR_TIMING, 1'b1, wd);
        tim_m = wd & 32'h0F0F_0F0F;
        access(ADDR_TIMING, 1'b0, 32'h0);
        checks++;
        if (r_rdata !== tim_m) begin
          failures++;
          $display("FAIL rand_timing[%0d]: got %h required %h", n, r_rdata, tim_m);
        end
      end else if (kind == 1) begin
        access(ADDR_CTRL, 1'b1, wd);
        rst_m = wd[1];
        access(ADDR_CTRL, 1'b0, 32'h0);
        checks++;
        if (r_rdata !== {30'b0, rst_m, 1'b0} || bus.lcd_rst_n !== rst_m) begin
          failures++;
          $display("FAIL rand_ctrl[%0d]: got %h pin=%b required %h", n, r_rdata, bus.lcd_rst_n, {30'b0, rst_m, 1'b0});
        end
      end else begin
        a  = {1'b0, 1'($urandom_range(0, 1))};
        wr = 1'($urandom_range(0, 1));
        panel_val = 16'($urandom);
        exp_cyc = exp_len(tim_m, wr);
        access(a, wr, wd);
        checks++;
        if (r_timeout || r_cycles != exp_cyc || r_cs_low != exp_cyc - 2) begin
          failures++;
          $display("FAIL rand_len[%0d]: got len=%0d cs_low=%0d required %0d %0d (tim=%h wr=%b)",
                   n, r_cycles, r_cs_low, exp_cyc, exp_cyc - 2, tim_m, wr);
        end
        checks++;
        if (r_wr_low != (wr ? flen(tim_m[11:8]) : 0) || r_rd_low != (wr ? 0 : flen(tim_m[19:16]))) begin
          failures++;
          $display("FAIL rand_strobe[%0d]: got wr_low=%0d rd_low=%0d (tim=%h wr=%b)", n, r_wr_low, r_rd_low, tim_m, wr);
        end
        checks++;
        if (r_bad_rs != 0 || r_bad_oe != 0 || r_bad_data != 0 || r_stray != 0 ||
            (!wr && r_rdata !== {16'h0, panel_val})) begin
          failures++;
          $display("FAIL rand_pins[%0d]: got rdata=%h bad rs/oe/data/stray=%0d/%0d/%0d/%0d required rdata=%h",
                   n, r_rdata, r_bad_rs, r_bad_oe, r_bad_data, r_stray, {16'h0, panel_val});
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    access(ADDR_TIMING, 1'b1, 32'h0101_0801);
    access(ADDR_CTRL, 1'b1, 32'h2);
    bus.avs_address   = ADDR_DATA;
    bus.avs_writedata = 32'h0000_5AA5;
    bus.avs_write     = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.lcd_wr_n !== 1'b0 || bus.lcd_cs_n !== 1'b0) begin
      failures++;
      $display("FAIL mid_strobe: got wr_n=%b cs_n=%b required 0 0", bus.lcd_wr_n, bus.lcd_cs_n);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.lcd_cs_n, bus.lcd_wr_n, bus.lcd_rd_n, bus.lcd_rst_n, bus.lcd_data_oe, bus.lcd_rs} !== 6'b111000 ||
        bus.lcd_data_out !== 16'h0) begin
      failures++;
      $display("FAIL mid_reset_pins: got cs/wr/rd/rst/oe/rs=%b data=%h required 111000 0000",
               {bus.lcd_cs_n, bus.lcd_wr_n, bus.lcd_rd_n, bus.lcd_rst_n, bus.lcd_data_oe, bus.lcd_rs}, bus.lcd_data_out);
    end
    @(negedge clk);
    bus.avs_write = 1'b0;
    reset = 1'b0;
    tim_m = 32'h0108_0201;
    rst_m = 1'b0;
    access(ADDR_CTRL, 1'b0, 32'h0);
    checks++;
    if (r_rdata !== 32'h0 || r_cycles != 1) begin
      failures++;
      $display("FAIL mid_status: got %h in %0d cycles required 0 in 1", r_rdata, r_cycles);
    end
    access(ADDR_TIMING, 1'b0, 32'h0);
    checks++;
    if (r_rdata !== tim_m) begin
      failures++;
      $display("FAIL mid_timing: got %h required %h", r_rdata, tim_m);
    end
  endtask

  initial begin
    reset             = 1'b1;
    bus.avs_address   = '0;
    bus.avs_read      = 1'b0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = '0;
    panel_val         = '0;
    tim_m             = 32'h0108_0201;
    rst_m             = 1'b0;
    test_reset;
    test_ctrl;
    test_cmd_write;
    test_timing_read;
    test_zero_timing;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qsys_mlcd_bus_ctrl.md
# qsys_mlcd_bus_ctrl

Avalon-MM slave that runs the 16-bit 8080-style MCU LCD bus in hardware, so Nios II software no longer bit-bangs CS/RS/WR/RD through PIOs. Each Avalon access to a command or data address becomes one complete LCD bus cycle, with programmable setup, strobe and hold timing. Avalon `waitrequest` stalls the CPU until that bus cycle finishes. The block sits in the Qsys system between the Nios II data master and the LCD connector pins, and it also drives the LCD reset line.

## Interface
- `TW`, 4: width of each timing field / phase counter
- `DW`, 16: LCD data bus width
- `clk`  in  1  system clock; everything is synchronous to its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `avs_address`  in  2  register select: 0 = CMD (RS=0), 1 = DATA (RS=1), 2 = TIMING, 3 = CTRL/STATUS
- `avs_read`  in  1  Avalon read
- `avs_write`  in  1  Avalon write
- `avs_writedata`  in  32  write data
- `avs_readdata`  out  32  read data; combinational mux, valid when `avs_waitrequest`=0
- `avs_waitrequest`  out  1  stall; combinational
- `lcd_cs_n`  out  1  chip select, active-low
- `lcd_rs`  out  1  register select (0 = command, 1 = data)
- `lcd_wr_n`  out  1  write strobe, active-low
- `lcd_rd_n`  out  1  read strobe, active-low
- `lcd_rst_n`  out  1  LCD reset, active-low
- `lcd_data_out`  out  DW  bus data driven to the LCD
- `lcd_data_oe`  out  1  tri-state enable for the pad (1 = drive)
- `lcd_data_in`  in  DW  bus data sampled from the LCD

## Operation
- **TIMING register (addr 2):**
  - Fields: [3:0] setup S, [11:8] write strobe W, [19:16] read strobe R, [27:24] hold H.
  - A field value of 0 is treated as 1.
  - Reset value is 0x0108_0201 (S=1, W=2, R=8, H=1).
  - Reads return the stored value; unused bits read 0.
- **CTRL/STATUS register (addr 3):**
  - Write: bit1 sets `lcd_rst_n`.
  - Read: bit0 = busy (FSM not IDLE), bit1 = `lcd_rst_n`.
- **State machine:** IDLE → SETUP → STROBE → HOLD → DONE → IDLE.
  - IDLE: a read or write to addr 0/1 captures RS = address[0], the direction and writedata[15:0], then goes to SETUP.
  - SETUP (S cycles): `lcd_cs_n`=0. On a write, `lcd_data_oe`=1 and `lcd_data_out` = captured data.
  - STROBE: `lcd_wr_n`=0 for W cycles on a write, or `lcd_rd_n`=0 for R cycles on a read. On a read, `lcd_data_in` is registered into the read latch on the last strobe cycle.
  - HOLD (H cycles): strobe returns high; CS, RS, data and OE are unchanged.
  - DONE (1 cycle): `lcd_cs_n`=1, `lcd_data_oe`=0, `avs_waitrequest`=0. On a read, `avs_readdata` = {16'b0, latch}.
- **`avs_waitrequest`:** 1 whenever `avs_read` or `avs_write` targets addr 0/1 and the state is not DONE.
  - Accesses to addr 2/3 complete with zero wait in IDLE only. In any other state they wait.
- **Read mux:** addr 0/1 return the latch, addr 2 returns TIMING, addr 3 returns STATUS.
- **Reset values:**
  - `lcd_cs_n`/`lcd_wr_n`/`lcd_rd_n` = 1.
  - `lcd_rs`, `lcd_data_out`, `lcd_data_oe`, `lcd_rst_n`, latch = 0; `avs_readdata` = 0.
  - FSM returns to IDLE and TIMING returns to its default.
  - `lcd_rst_n` = 0 means the panel stays held in reset until software releases it.
- **Reset during a bus cycle:** all pins go to their idle values asynchronously. The pending Avalon access is abandoned.
- **Timing changes:** TIMING is sampled only in IDLE. It cannot change during a cycle, because writes to it wait.
- `avs_read` and `avs_write` both asserted is illegal; write takes priority.

## Timing
- Accept cycle T0 in IDLE. Then SETUP for T1..TS, STROBE for W or R cycles, HOLD for H cycles, DONE at T(1+S+W/R+H).
- Total Avalon access length = S+W+H+2 cycles for a write (default 6) and S+R+H+2 for a read (default 12).
- `lcd_data_out` is stable from the first SETUP cycle through the last HOLD cycle, which encloses the `lcd_wr_n` pulse.
- Back-to-back accesses: DONE → IDLE → accept, so there are at least 2 `lcd_cs_n`-high cycles between LCD cycles.
- The read sample point is the rising edge that ends the last `lcd_rd_n`-low cycle.

## Structure
- Package `qsys_mlcd_pkg` holds:
  - the state enum (IDLE, SETUP, STROBE, HOLD, DONE);
  - address constants ADDR_CMD / ADDR_DATA / ADDR_TIMING / ADDR_CTRL;
  - TIMING reset default and field bit positions.
- No sub-module: a single phase down-counter, loaded with the next phase length on each transition, lives inline.

## Test plan
- After reset: `lcd_cs_n`/`lcd_wr_n`/`lcd_rd_n`=1, `lcd_rst_n`=0, `lcd_data_oe`=0. Read addr 2 → 0x0108_0201. Read addr 3 → 0x0.
- Write 0x0002 to addr 3 → `lcd_rst_n`=1 with zero wait. Read addr 3 → 0x2.
- Write 0x002C to addr 0 with default timing:
  - `avs_waitrequest` high 5 cycles, low on the 6th.
  - `lcd_rs`=0, `lcd_wr_n` low exactly 2 cycles, `lcd_data_out`=0x002C from CS-low to CS-high.
- Program TIMING=0x0203_0402, then read addr 1 with the LCD model driving 0xA55A:
  - `lcd_rd_n` low 3 cycles, `lcd_rs`=1;
  - access length 2+3+2+2 = 9 cycles; `avs_readdata`=0x0000_A55A.
- Field value 0 (TIMING=0) → each phase lasts 1 cycle; a write takes 5 cycles.
- Assert `reset` during the STROBE phase of a write → all pins return to idle values immediately; FSM in IDLE; TIMING back to its default.
